// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the ALU share arbiter.
package alu_arb_pkg;

  localparam int unsigned AluW        = 32;
  localparam int unsigned OpW         = 5;
  localparam int unsigned StatW       = 16;
  localparam int unsigned NReqDefault = 4;

  // ALU opcodes understood by the downstream ALU.
  localparam logic [OpW-1:0] OP_ADD = 5'd0;
  localparam logic [OpW-1:0] OP_SUB = 5'd1;
  localparam logic [OpW-1:0] OP_AND = 5'd2;
  localparam logic [OpW-1:0] OP_OR  = 5'd3;
  localparam logic [OpW-1:0] OP_SLL = 5'd4;
  localparam logic [OpW-1:0] OP_SRA = 5'd5;

  typedef logic [AluW-1:0] word_t;

  // One operation as presented to the ALU.
  typedef struct packed {
    word_t          opa;
    word_t          opb;
    logic [OpW-1:0] opcode;
    logic [OpW-1:0] shamt;
  } alu_op_t;

  // Saturating increment for the per-requester accept counters.
  function automatic logic [StatW-1:0] sat_inc(input logic [StatW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request / ALU / response bundle between issuing units, the arbiter and the ALU.
// The arbiter connects through the slave modport; the issuing side uses master.
interface alu_share_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);

  // Requester side
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_lock;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*AluW-1:0] req_opa;
  logic [N_REQ*AluW-1:0] req_opb;
  logic [N_REQ*OpW-1:0]  req_opcode;
  logic [N_REQ*OpW-1:0]  req_shamt;

  // ALU side
  logic [AluW-1:0]       alu_operand_a;
  logic [AluW-1:0]       alu_operand_b;
  logic [OpW-1:0]        alu_opcode;
  logic [OpW-1:0]        alu_shiftamt;
  logic [AluW-1:0]       alu_result;
  logic                  alu_ne;
  logic                  alu_gt;
  logic                  alu_ovf;

  // Response side
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [AluW-1:0]       rsp_result;
  logic                  rsp_ne;
  logic                  rsp_gt;
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_lock, req_opa, req_opb, req_opcode, req_shamt,
    output alu_result, alu_ne, alu_gt, alu_ovf, rsp_ready,
    input  req_ready, alu_operand_a, alu_operand_b, alu_opcode, alu_shiftamt,
    input  rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_gt, rsp_ovf
  );

  modport slave (
    input  req_valid, req_lock, req_opa, req_opb, req_opcode, req_shamt,
    input  alu_result, alu_ne, alu_gt, alu_ovf, rsp_ready,
    output req_ready, alu_operand_a, alu_operand_b, alu_opcode, alu_shiftamt,
    output rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_gt, rsp_ovf
  );

endinterface

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping from N_REQ-1 back to 0. A held lock pins the grant on rr_ptr.
module alu_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  input  logic             lock_hold_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             any_valid_o
);

  // One extra bit so rr_ptr + k never overflows before the modulo fold.
  localparam int unsigned   SumW  = ID_W + 1;
  localparam logic [SumW-1:0] NReqW = SumW'(N_REQ);

  logic            found;
  logic [SumW-1:0] sum;

  // Search from rr_ptr upward; the lock case short-circuits to rr_ptr.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_valid_o = |valid_i;
    found       = 1'b0;
    sum         = '0;
    if (lock_hold_i && valid_i[rr_ptr_i]) begin
      grant_idx_o = rr_ptr_i;
      found       = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr_ptr_i} + SumW'(k);
        if (sum >= NReqW) begin
          sum = sum - NReqW;
        end
        if (!found && valid_i[sum[ID_W-1:0]]) begin
          found       = 1'b1;
          grant_idx_o = sum[ID_W-1:0];
        end
      end
    end
    if (found) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 32-bit ALU between N_REQ requesters. A round-robin
// grant drives the ALU inputs; the ALU outputs are captured into a one-entry
// response register tagged with the requester id.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester saturating
// accept counters (stat_clear_i / stat_grants_o).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef ALU_ARB_STATS_EN
  input  logic                   stat_clear_i,
  output logic [N_REQ*StatW-1:0] stat_grants_o,
`endif
  alu_share_arbiter_if.slave     bus
);

  // Arbitration state
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_hold_q, lock_hold_d;

  // Response register
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  word_t           rsp_result_q, rsp_result_d;
  logic            rsp_ne_q, rsp_ne_d;
  logic            rsp_gt_q, rsp_gt_d;
  logic            rsp_ovf_q, rsp_ovf_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             any_valid;
  logic             can_issue;
  logic             accept;
  alu_op_t          sel_op;

  alu_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid_i     (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .lock_hold_i (lock_hold_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_valid_o (any_valid)
  );

  // Handshake: the slot is free when empty or being drained this cycle.
  always_comb begin
    can_issue     = ~rsp_valid_q | bus.rsp_ready;
    bus.req_ready = can_issue ? grant : '0;
    accept        = any_valid & can_issue;
  end

  // Operand mux: granted requester's fields whenever anyone is valid, else zero.
  always_comb begin
    sel_op = '0;
    if (any_valid) begin
      sel_op.opa    = bus.req_opa[int'(grant_idx)*AluW +: AluW];
      sel_op.opb    = bus.req_opb[int'(grant_idx)*AluW +: AluW];
      sel_op.opcode = bus.req_opcode[int'(grant_idx)*OpW +: OpW];
      sel_op.shamt  = bus.req_shamt[int'(grant_idx)*OpW +: OpW];
    end
    bus.alu_operand_a = sel_op.opa;
    bus.alu_operand_b = sel_op.opb;
    bus.alu_opcode    = sel_op.opcode;
    bus.alu_shiftamt  = sel_op.shamt;
  end

  // Next round-robin pointer and lock state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_hold_d = lock_hold_q;
    if (accept) begin
      if (bus.req_lock[grant_idx]) begin
        rr_ptr_d    = grant_idx;
        lock_hold_d = 1'b1;
      end else begin
        rr_ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        lock_hold_d = 1'b0;
      end
    end else if (lock_hold_q && !bus.req_valid[rr_ptr_q]) begin
      // Locked owner went away: release so normal rotation resumes.
      lock_hold_d = 1'b0;
    end
  end

  // Next response register: capture on accept, drain when consumed.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ne_d     = rsp_ne_q;
    rsp_gt_d     = rsp_gt_q;
    rsp_ovf_d    = rsp_ovf_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_idx;
      rsp_result_d = bus.alu_result;
      rsp_ne_d     = bus.alu_ne;
      rsp_gt_d     = bus.alu_gt;
      rsp_ovf_d    = bus.alu_ovf;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any held response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_hold_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ne_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_hold_q  <= lock_hold_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ne_q     <= rsp_ne_d;
      rsp_gt_q     <= rsp_gt_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // Response outputs straight from the register.
  always_comb begin
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_id     = rsp_id_q;
    bus.rsp_result = rsp_result_q;
    bus.rsp_ne     = rsp_ne_q;
    bus.rsp_gt     = rsp_gt_q;
    bus.rsp_ovf    = rsp_ovf_q;
  end

`ifdef ALU_ARB_STATS_EN
  logic [StatW-1:0] stat_q [N_REQ];
  logic [StatW-1:0] stat_d [N_REQ];

  // Counter next state: clear beats increment.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear_i) begin
        stat_d[i] = '0;
      end else if (accept && grant[i]) begin
        stat_d[i] = sat_inc(stat_q[i]);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Flatten counters, requester i at [16i+15:16i].
  always_comb begin
    stat_grants_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      stat_grants_o[i*StatW +: StatW] = stat_q[i];
    end
  end
`endif

endmodule
